eaf_bloom_filter_array: RTL
===========================

// Module: eaf_bloom_filter_array
// PURPOSE
//  Bloom-filter storage stage of the Evicted Address Filter (EAF); sits directly downstream of the hash stage.
//  Consumes the seven per-prime indices and performs one operation per accepted request:
//   - insert: sets one bit in each of seven bit arrays.
//   - test: ANDs the seven addressed bits and returns priority_level to the cache.
//  Counts insertions and self-clears all arrays once MAX_ENTRIES addresses have been inserted.
// PARAMETERS
//  SZ1..SZ7      2,4,8,32,128,2048,8192  bit-array sizes (power of 2); idx widths IW_n = $clog2(SZn), min 1
//  MAX_ENTRIES   8                       insertions before automatic clear (cache size)
//  CNT_W         $clog2(MAX_ENTRIES+1)   insertion counter width
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        asynchronous active-low reset
//  req_valid       in   1        request present; indices and op stable while valid && !req_ready
//  req_ready       out  1        block accepts request this cycle
//  insert_resp_i   in   1        op: insert addressed bits
//  test_resp_i     in   1        op: test addressed bits
//  idx1..idx7      in   IW_n     per-prime indices from hash stage
//  flush_i         in   1        synchronous clear request (e.g. context switch)
//  resp_valid      out  1        one-cycle pulse: test result valid
//  priority_level  out  1        1 = address present (all 7 bits set); held until next resp_valid
//  insert_count    out  CNT_W    inserts since last clear
//  clearing        out  1        high during CLEAR state
// BEHAVIOUR
//  Reset (rst=0, async): all array bits 0; insert_count 0; resp_valid 0; priority_level 0; FSM=IDLE;
//   req_ready 0 during reset and rises in the first cycle after release.
//  FSM states:
//   IDLE  : req_ready=1. Accept on req_valid && req_ready.
//   CLEAR : req_ready=0, clearing=1; exactly one cycle; all arrays zeroed, insert_count->0, then IDLE.
//  Accepted request handling:
//   - test only: priority_level <= &{arr1[idx1],...,arr7[idx7]}; resp_valid=1 on the next cycle (latency 1).
//   - insert only: set arrN[idxN] for all N; insert_count+1; no response.
//   - both set: test evaluates pre-insert contents; insert then applies in the same edge; resp_valid next cycle.
//   - neither set: request consumed, no effect, no response.
//  Auto-clear: the insert that brings insert_count to MAX_ENTRIES writes its bits.
//   Next state is CLEAR (count shows MAX_ENTRIES for one cycle, then 0).
//   A test accepted in the same cycle still responds, against the pre-insert state.
//  flush_i in IDLE: next state is CLEAR.
//   A request accepted in the same cycle is still executed (test responds); its inserted bits are cleared.
//  flush_i during CLEAR is absorbed: single CLEAR cycle, no extension.
//  Index arithmetic: indices used as-is, no modulo; widths exactly IW_n; no out-of-range possible.
//  Counter never exceeds MAX_ENTRIES; no wrap.
//  Re-inserting an already-present address still increments the count (no duplicate detection).
//  Reset asserted mid-request or mid-CLEAR: immediate return to reset state; in-flight test response dropped.
// STRUCTURE
//  eaf_pkg:
//   - localparams for SZ1..SZ7 and IW_n; MAX_ENTRIES.
//   - typedef enum logic {ST_IDLE, ST_CLEAR} eaf_state_e.
//   - typedef struct packed eaf_idx_t bundling idx1..idx7, shared with the hash stage.
//  Sub-module eaf_bit_array #(SIZE), instantiated 7x:
//   - ports clk, rst, clr, set_en, set_idx, rd_idx, rd_bit.
//   - combinational read; set and clear on the clock edge, clr wins over set_en.
//  Top: FSM, counter, response register, 7-way AND.
// TESTING
//  1 Reset, then test idx={1,3,5,17,100,1500,8000} -> resp_valid 1 cycle after accept, priority_level=0.
//  2 Insert same idx, then test same -> priority_level=1, insert_count=1.
//    Test idx differing only in idx7=7999 -> 0.
//  3 Insert 8 distinct idx sets -> after 8th: count=8 for 1 cycle, clearing=1, req_ready=0 for 1 cycle.
//    Then count=0 and retest of set #1 -> 0.
//  4 Insert+test asserted together on fresh idx -> priority_level=0 (pre-insert).
//    Repeat the same request -> 1, count=2.
//  5 flush_i with accepted test in same cycle -> test responds; CLEAR follows.
//    Prior inserts test 0 afterwards; flush_i held 3 cycles gives a single CLEAR cycle.
//  6 Assert rst in the CLEAR cycle and in the cycle after a test accept -> no resp_valid pulse.
//    All outputs at reset values; req_ready returns 1 after release.

Source files
------------

// File: rtl/eaf_pkg.sv
// Shared types and sizing for the EAF Bloom-filter storage stage and the hash stage feeding it.
package eaf_pkg;

    localparam int SZ1 = 2;
    localparam int SZ2 = 4;
    localparam int SZ3 = 8;
    localparam int SZ4 = 32;
    localparam int SZ5 = 128;
    localparam int SZ6 = 2048;
    localparam int SZ7 = 8192;
    localparam int NUM_ARR = 7;
    localparam int MAX_ENTRIES = 8;

    function automatic int eaf_iw(input int sz);
        return (sz > 1) ? $clog2(sz) : 1;
    endfunction

    // Array size by zero-based array number, for generate loops
    function automatic int eaf_size(input int n);
        case (n)
            0: return SZ1;
            1: return SZ2;
            2: return SZ3;
            3: return SZ4;
            4: return SZ5;
            5: return SZ6;
            default: return SZ7;
        endcase
    endfunction

    localparam int IW1 = eaf_iw(SZ1);
    localparam int IW2 = eaf_iw(SZ2);
    localparam int IW3 = eaf_iw(SZ3);
    localparam int IW4 = eaf_iw(SZ4);
    localparam int IW5 = eaf_iw(SZ5);
    localparam int IW6 = eaf_iw(SZ6);
    localparam int IW7 = eaf_iw(SZ7);

    typedef enum logic {ST_IDLE, ST_CLEAR} eaf_state_e;

    typedef struct packed {
        logic [IW7-1:0] i7;
        logic [IW6-1:0] i6;
        logic [IW5-1:0] i5;
        logic [IW4-1:0] i4;
        logic [IW3-1:0] i3;
        logic [IW2-1:0] i2;
        logic [IW1-1:0] i1;
    } eaf_idx_t;

endpackage

// File: rtl/eaf_bit_array.sv
// One Bloom-filter bit array: combinational read, set/clear on the clock edge.
module eaf_bit_array #(
    parameter int SIZE = 2,
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_bit
);

    logic [SIZE-1:0] bits;

    assign rd_bit = bits[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bits <= '0;
        else if (clr)
            bits <= '0;
        else if (set_en)
            bits[set_idx] <= 1'b1;
    end

endmodule

// File: rtl/eaf_bloom_filter_array.sv
// EAF Bloom-filter storage: seven bit arrays, insert/test handshake, insertion counter with auto-clear.
module eaf_bloom_filter_array
    import eaf_pkg::*;
#(
    parameter int MAX_ENT = MAX_ENTRIES,
    parameter int CNT_W   = $clog2(MAX_ENT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             insert_resp_i,
    input  logic             test_resp_i,
    input  logic [IW1-1:0]   idx1,
    input  logic [IW2-1:0]   idx2,
    input  logic [IW3-1:0]   idx3,
    input  logic [IW4-1:0]   idx4,
    input  logic [IW5-1:0]   idx5,
    input  logic [IW6-1:0]   idx6,
    input  logic [IW7-1:0]   idx7,
    input  logic             flush_i,
    output logic             resp_valid,
    output logic             priority_level,
    output logic [CNT_W-1:0] insert_count,
    output logic             clearing
);

    eaf_state_e           state;
    eaf_idx_t             idx_s;
    logic                 init_done;
    logic                 flush_q;
    logic [NUM_ARR-1:0]   rd_bits;
    logic                 acc, ins_acc, tst_acc, flush_rise, hit;

    assign idx_s = '{i7: idx7, i6: idx6, i5: idx5, i4: idx4, i3: idx3, i2: idx2, i1: idx1};

    // init_done keeps req_ready low until the first edge after reset release
    assign req_ready  = init_done && (state == ST_IDLE);
    assign clearing   = (state == ST_CLEAR);
    assign acc        = req_valid && req_ready;
    assign ins_acc    = acc && insert_resp_i;
    assign tst_acc    = acc && test_resp_i;
    // A flush held high over several cycles counts as a single clear request
    assign flush_rise = flush_i && !flush_q;
    assign hit        = &rd_bits;

    for (genvar g = 0; g < NUM_ARR; g++) begin : g_arr
        localparam int SZ = eaf_size(g);
        localparam int W  = eaf_iw(SZ);
        logic [W-1:0] ix;
        case (g)
            0: assign ix = idx_s.i1;
            1: assign ix = idx_s.i2;
            2: assign ix = idx_s.i3;
            3: assign ix = idx_s.i4;
            4: assign ix = idx_s.i5;
            5: assign ix = idx_s.i6;
            default: assign ix = idx_s.i7;
        endcase
        eaf_bit_array #(.SIZE(SZ)) u_arr (
            .clk    (clk),
            .rst    (rst),
            .clr    (clearing),
            .set_en (ins_acc),
            .set_idx(ix),
            .rd_idx (ix),
            .rd_bit (rd_bits[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            init_done      <= 1'b0;
            flush_q        <= 1'b0;
            insert_count   <= '0;
            resp_valid     <= 1'b0;
            priority_level <= 1'b0;
        end else begin
            init_done  <= 1'b1;
            flush_q    <= flush_i;
            resp_valid <= tst_acc;
            // Test reads pre-insert contents: the arrays only update on this same edge
            if (tst_acc)
                priority_level <= hit;
            if (state == ST_CLEAR) begin
                insert_count <= '0;
                state        <= ST_IDLE;
            end else begin
                if (ins_acc)
                    insert_count <= insert_count + 1'b1;
                if (flush_rise || (ins_acc && insert_count == CNT_W'(MAX_ENT - 1)))
                    state <= ST_CLEAR;
            end
        end
    end

endmodule
